// File: rtl/ldm_stm_sequencer_if.sv
// Signal bundle between the LDM/STM sequencer and the control unit, register file and memory.
// The sequencer connects through the slave modport and the driving side through the master modport.
interface ldm_stm_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic [31:0]       IR;
  logic [ADDR_W-1:0] rn_val;
  logic              mem_done;
  logic [4:0]        MLR_to_Reg;
  logic [1:0]        ma;
  logic [1:0]        mc;
  logic              RFload;
  logic              wb_sel;
  logic [ADDR_W-1:0] wb_value;
  logic              mem_req;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic              busy;
  logic              done;

  modport slave (
    input  start, IR, rn_val, mem_done,
    output MLR_to_Reg, ma, mc, RFload, wb_sel, wb_value,
           mem_req, mem_rw, mem_addr, busy, done
  );

  modport master (
    output start, IR, rn_val, mem_done,
    input  MLR_to_Reg, ma, mc, RFload, wb_sel, wb_value,
           mem_req, mem_rw, mem_addr, busy, done
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks the register list in ascending order, runs one memory
// handshake per register, writes loaded data back to the register file and applies base writeback.
module ldm_stm_sequencer #(
  parameter int ADDR_W = 32,
  parameter int LIST_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  ldm_stm_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(LIST_W + 1);
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(3'd4);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BASE = 3'd1,
    S_NEXT = 3'd2,
    S_XFER = 3'd3,
    S_LOAD = 3'd4,
    S_WB   = 3'd5,
    S_DONE = 3'd6
  } state_e;

  function automatic logic [CNT_W-1:0] popcount(input logic [LIST_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = {CNT_W{1'b0}};
    for (int i = 0; i < LIST_W; i++) begin
      c = c + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  function automatic logic [4:0] lowest_set(input logic [LIST_W-1:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = 5'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  state_e            state_q, state_d, tail_s;
  logic [LIST_W-1:0] list_q, list_d, list_in_s;
  logic [CNT_W-1:0]  n_q, n_d;
  logic              l_q, l_d, w_q, w_d, u_q, u_d, p_q, p_d;
  logic              rn_in_list_q, rn_in_list_d;
  logic [4:0]        reg_q, reg_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wb_value_q, wb_value_d;
  logic [ADDR_W-1:0] four_n_s, rn_up_s, rn_dn_s;
  logic              list_empty_s, do_wb_s, ir_unused_s;

  logic [1:0] ma_q, ma_d, mc_q, mc_d;
  logic       rfload_q, rfload_d, wb_sel_q, wb_sel_d;
  logic       mem_req_q, mem_req_d, mem_rw_q, mem_rw_d;
  logic       busy_q, busy_d, done_q, done_d;

  assign list_in_s    = bus.IR[LIST_W-1:0];
  assign ir_unused_s  = ^{bus.IR[31:25], bus.IR[22]};
  assign list_empty_s = (list_q == {LIST_W{1'b0}});
  // An LDM that reloads its own base keeps the loaded value instead of the written-back one.
  assign do_wb_s      = w_q & ~(l_q & rn_in_list_q);
  assign tail_s       = do_wb_s ? S_WB : S_DONE;
  assign four_n_s     = {{(ADDR_W-CNT_W-2){1'b0}}, n_q, 2'b00};
  assign rn_up_s      = bus.rn_val + four_n_s;
  assign rn_dn_s      = bus.rn_val - four_n_s;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_BASE;
        else           state_d = S_IDLE;
      end
      S_BASE: begin
        if (list_empty_s) state_d = S_DONE;
        else              state_d = S_NEXT;
      end
      S_NEXT: state_d = S_XFER;
      S_XFER: begin
        if (!bus.mem_done)    state_d = S_XFER;
        else if (l_q)         state_d = S_LOAD;
        else if (list_empty_s) state_d = tail_s;
        else                  state_d = S_NEXT;
      end
      S_LOAD: begin
        if (list_empty_s) state_d = tail_s;
        else              state_d = S_NEXT;
      end
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up with the state register
  always_comb begin
    ma_d      = 2'd0;
    mc_d      = 2'd0;
    rfload_d  = 1'b0;
    wb_sel_d  = 1'b0;
    mem_req_d = 1'b0;
    mem_rw_d  = 1'b0;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    case (state_d)
      S_IDLE: busy_d = 1'b0;
      S_XFER: begin
        mem_req_d = 1'b1;
        mem_rw_d  = l_q;
        ma_d      = l_q ? 2'd0 : 2'd3;
      end
      S_LOAD: begin
        mc_d     = 2'd3;
        rfload_d = 1'b1;
      end
      S_WB: begin
        mc_d     = 2'd2;
        rfload_d = 1'b1;
        wb_sel_d = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: busy_d = 1'b1;
    endcase
  end

  // Control output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ma_q      <= 2'd0;
      mc_q      <= 2'd0;
      rfload_q  <= 1'b0;
      wb_sel_q  <= 1'b0;
      mem_req_q <= 1'b0;
      mem_rw_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ma_q      <= ma_d;
      mc_q      <= mc_d;
      rfload_q  <= rfload_d;
      wb_sel_q  <= wb_sel_d;
      mem_req_q <= mem_req_d;
      mem_rw_q  <= mem_rw_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Datapath next values: instruction latch, address walk and register pick
  always_comb begin
    list_d       = list_q;
    n_d          = n_q;
    l_d          = l_q;
    w_d          = w_q;
    u_d          = u_q;
    p_d          = p_q;
    rn_in_list_d = rn_in_list_q;
    reg_d        = reg_q;
    addr_d       = addr_q;
    wb_value_d   = wb_value_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          list_d       = list_in_s;
          n_d          = popcount(list_in_s);
          l_d          = bus.IR[20];
          w_d          = bus.IR[21];
          u_d          = bus.IR[23];
          p_d          = bus.IR[24];
          rn_in_list_d = list_in_s[bus.IR[19:16]];
        end else begin
          list_d = list_q;
        end
      end
      S_BASE: begin
        case ({p_q, u_q})
          2'b01:   addr_d = bus.rn_val;
          2'b11:   addr_d = bus.rn_val + WORD_BYTES;
          2'b00:   addr_d = rn_dn_s + WORD_BYTES;
          2'b10:   addr_d = rn_dn_s;
          default: addr_d = bus.rn_val;
        endcase
        wb_value_d = u_q ? rn_up_s : rn_dn_s;
      end
      S_NEXT: begin
        reg_d  = lowest_set(list_q);
        list_d = list_q & (list_q - {{(LIST_W-1){1'b0}}, 1'b1});
      end
      S_XFER: begin
        if (bus.mem_done && !l_q) addr_d = addr_q + WORD_BYTES;
        else                      addr_d = addr_q;
      end
      S_LOAD:  addr_d = addr_q + WORD_BYTES;
      default: addr_d = addr_q;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      list_q       <= {LIST_W{1'b0}};
      n_q          <= {CNT_W{1'b0}};
      l_q          <= 1'b0;
      w_q          <= 1'b0;
      u_q          <= 1'b0;
      p_q          <= 1'b0;
      rn_in_list_q <= 1'b0;
      reg_q        <= 5'd0;
      addr_q       <= {ADDR_W{1'b0}};
      wb_value_q   <= {ADDR_W{1'b0}};
    end else begin
      list_q       <= list_d;
      n_q          <= n_d;
      l_q          <= l_d;
      w_q          <= w_d;
      u_q          <= u_d;
      p_q          <= p_d;
      rn_in_list_q <= rn_in_list_d;
      reg_q        <= reg_d;
      addr_q       <= addr_d;
      wb_value_q   <= wb_value_d;
    end
  end

  assign bus.MLR_to_Reg = reg_q;
  assign bus.ma         = ma_q;
  assign bus.mc         = mc_q;
  assign bus.RFload     = rfload_q;
  assign bus.wb_sel     = wb_sel_q;
  assign bus.wb_value   = wb_value_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_rw     = mem_rw_q;
  assign bus.mem_addr   = addr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: per-scenario tasks with hand-computed expectations.
module tb_ldm_stm_sequencer;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ldm_stm_sequencer_if #(.ADDR_W(ADDR_W)) bus ();
  ldm_stm_sequencer #(.ADDR_W(ADDR_W), .LIST_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  // observations from the last run_op
  int n_x, n_l, done_cnt, lat, busy_cnt, req_cycles, addr_unstable, busy_after, ma_bad, mc_bad;
  logic [31:0] x_addr [0:15];
  logic        x_rw   [0:15];
  logic [4:0]  x_reg  [0:15];
  logic [1:0]  x_ma   [0:15];
  logic [1:0]  l_mc   [0:15];
  logic [4:0]  l_reg  [0:15];
  logic        l_wbsel[0:15];
  logic [31:0] l_wbval[0:15];
  logic [78:0] snap;
  bit          aborted;

  function automatic logic [78:0] outs();
    return {bus.MLR_to_Reg, bus.ma, bus.mc, bus.RFload, bus.wb_sel, bus.wb_value,
            bus.mem_req, bus.mem_rw, bus.mem_addr, bus.busy, bus.done};
  endfunction

  // Issues one start, plays memory with ack_wait extra wait cycles and records what happens.
  task automatic run_op(input logic [31:0] ir, input logic [31:0] rn, input int ack_wait,
                        input int stray_k, input int abort_xfer);
    int wait_cnt, done_k, post_abort;
    logic prev_req;
    logic [31:0] prev_addr;
    n_x = 0; n_l = 0; done_cnt = 0; lat = 0; busy_cnt = 0; req_cycles = 0;
    addr_unstable = 0; busy_after = 0; ma_bad = 0; mc_bad = 0; snap = '1; aborted = 0;
    wait_cnt = 0; done_k = -1; post_abort = 0; prev_req = 1'b0; prev_addr = 32'd0;
    @(negedge clk);
    bus.start = 1'b1; bus.IR = ir; bus.rn_val = rn; bus.mem_done = 1'b0;
    for (int k = 1; k < 300; k++) begin
      @(negedge clk);
      bus.start = (k == stray_k);
      if (k == stray_k) bus.IR = 32'h0010_0001;
      if (aborted) begin reset = 1'b0; post_abort++; end
      if (bus.busy) busy_cnt++;
      if (done_k >= 0 && bus.busy) busy_after++;
      if (bus.done) begin
        done_cnt++;
        if (done_k < 0) begin done_k = k; lat = k + 1; end
      end
      if (bus.ma == 2'd3 && !(bus.mem_req && !bus.mem_rw)) ma_bad++;
      if (bus.mc == 2'd3 && !bus.RFload) mc_bad++;
      if (bus.RFload) begin
        if (n_l < 16) begin
          l_mc[n_l] = bus.mc; l_reg[n_l] = bus.MLR_to_Reg;
          l_wbsel[n_l] = bus.wb_sel; l_wbval[n_l] = bus.wb_value;
        end
        n_l++;
      end
      if (bus.mem_req) begin
        req_cycles++;
        if (prev_req && bus.mem_addr !== prev_addr) addr_unstable++;
        wait_cnt++;
        if (!aborted && abort_xfer >= 0 && n_x == abort_xfer) begin
          bus.mem_done = 1'b0;
          #2 reset = 1'b1;
          #1 snap = outs();
          aborted = 1;
          n_l = 0; done_cnt = 0; busy_cnt = 0; req_cycles = 0;
        end else if (wait_cnt > ack_wait) begin
          if (n_x < 16) begin
            x_addr[n_x] = bus.mem_addr; x_rw[n_x] = bus.mem_rw;
            x_reg[n_x] = bus.MLR_to_Reg; x_ma[n_x] = bus.ma;
          end
          n_x++;
          bus.mem_done = 1'b1;
        end else begin
          bus.mem_done = 1'b0;
        end
      end else begin
        wait_cnt = 0;
        bus.mem_done = 1'b0;
      end
      prev_req = bus.mem_req;
      prev_addr = bus.mem_addr;
      if (done_k >= 0 && k >= done_k + 3) break;
      if (aborted && post_abort >= 6) break;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (outs() !== 79'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs()); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_stm_ia();
    run_op(32'h00A1_0005, 32'h0000_0100, 1, -1, -1);
    checks++; if (n_x !== 2) begin failures++; $display("FAIL stm_ia_xfers got=%0d exp=2", n_x); end
    checks++; if (x_addr[0] !== 32'h100 || x_addr[1] !== 32'h104) begin failures++;
      $display("FAIL stm_ia_addr got=%h,%h exp=100,104", x_addr[0], x_addr[1]); end
    checks++; if (x_reg[0] !== 5'd0 || x_reg[1] !== 5'd2) begin failures++;
      $display("FAIL stm_ia_regs got=%0d,%0d exp=0,2", x_reg[0], x_reg[1]); end
    checks++; if (x_rw[0] !== 1'b0 || x_ma[0] !== 2'd3 || x_ma[1] !== 2'd3) begin failures++;
      $display("FAIL stm_ia_rw_ma got=rw%b ma%0d/%0d exp=rw0 ma3/3", x_rw[0], x_ma[0], x_ma[1]); end
    checks++; if (n_l !== 1) begin failures++; $display("FAIL stm_ia_rfload_count got=%0d exp=1", n_l); end
    checks++; if (l_mc[0] !== 2'd2 || l_wbsel[0] !== 1'b1 || l_wbval[0] !== 32'h108) begin failures++;
      $display("FAIL stm_ia_wb got=mc%0d sel%b val%h exp=mc2 sel1 val108", l_mc[0], l_wbsel[0], l_wbval[0]); end
    checks++; if (done_cnt !== 1 || lat !== 10) begin failures++;
      $display("FAIL stm_ia_done got=cnt%0d lat%0d exp=cnt1 lat10", done_cnt, lat); end
    checks++; if (ma_bad !== 0 || mc_bad !== 0) begin failures++;
      $display("FAIL stm_ia_selects got=ma_bad%0d mc_bad%0d exp=0,0", ma_bad, mc_bad); end
  endtask

  task automatic test_ldm_db();
    run_op(32'h0112_8003, 32'h0000_0200, 0, -1, -1);
    checks++; if (n_x !== 3) begin failures++; $display("FAIL ldm_db_xfers got=%0d exp=3", n_x); end
    checks++; if (x_addr[0] !== 32'h1F4 || x_addr[1] !== 32'h1F8 || x_addr[2] !== 32'h1FC) begin failures++;
      $display("FAIL ldm_db_addr got=%h,%h,%h exp=1f4,1f8,1fc", x_addr[0], x_addr[1], x_addr[2]); end
    checks++; if (x_rw[0] !== 1'b1 || x_ma[0] !== 2'd0) begin failures++;
      $display("FAIL ldm_db_rw_ma got=rw%b ma%0d exp=rw1 ma0", x_rw[0], x_ma[0]); end
    checks++; if (n_l !== 3) begin failures++; $display("FAIL ldm_db_rfload_count got=%0d exp=3", n_l); end
    checks++; if (l_reg[0] !== 5'd0 || l_reg[1] !== 5'd1 || l_reg[2] !== 5'd15) begin failures++;
      $display("FAIL ldm_db_regs got=%0d,%0d,%0d exp=0,1,15", l_reg[0], l_reg[1], l_reg[2]); end
    checks++; if (l_mc[0] !== 2'd3 || l_mc[2] !== 2'd3 || l_wbsel[2] !== 1'b0) begin failures++;
      $display("FAIL ldm_db_mc got=mc%0d/%0d sel%b exp=mc3/3 sel0", l_mc[0], l_mc[2], l_wbsel[2]); end
    checks++; if (done_cnt !== 1 || lat !== 12) begin failures++;
      $display("FAIL ldm_db_done got=cnt%0d lat%0d exp=cnt1 lat12", done_cnt, lat); end
    checks++; if (bus.wb_value !== 32'h1F4) begin failures++;
      $display("FAIL ldm_db_wb_value got=%h exp=1f4", bus.wb_value); end
    checks++; if (ma_bad !== 0 || mc_bad !== 0) begin failures++;
      $display("FAIL ldm_db_selects got=ma_bad%0d mc_bad%0d exp=0,0", ma_bad, mc_bad); end
  endtask

  task automatic test_ldm_base_in_list();
    run_op(32'h00B4_0010, 32'h0000_3000, 2, -1, -1);
    checks++; if (n_x !== 1 || x_addr[0] !== 32'h3000 || x_rw[0] !== 1'b1) begin failures++;
      $display("FAIL ldm_rn_xfer got=n%0d addr%h rw%b exp=n1 addr3000 rw1", n_x, x_addr[0], x_rw[0]); end
    checks++; if (n_l !== 1 || l_reg[0] !== 5'd4 || l_mc[0] !== 2'd3 || l_wbsel[0] !== 1'b0) begin failures++;
      $display("FAIL ldm_rn_load got=n%0d reg%0d mc%0d sel%b exp=n1 reg4 mc3 sel0", n_l, l_reg[0], l_mc[0], l_wbsel[0]); end
    checks++; if (done_cnt !== 1 || lat !== 8) begin failures++;
      $display("FAIL ldm_rn_done got=cnt%0d lat%0d exp=cnt1 lat8", done_cnt, lat); end
  endtask

  task automatic test_empty_list();
    run_op(32'h00A1_0000, 32'h0000_0040, 0, -1, -1);
    checks++; if (busy_cnt !== 2) begin failures++; $display("FAIL empty_busy got=%0d exp=2", busy_cnt); end
    checks++; if (done_cnt !== 1 || lat !== 3) begin failures++;
      $display("FAIL empty_done got=cnt%0d lat%0d exp=cnt1 lat3", done_cnt, lat); end
    checks++; if (req_cycles !== 0 || n_l !== 0) begin failures++;
      $display("FAIL empty_activity got=req%0d rfload%0d exp=0,0", req_cycles, n_l); end
  endtask

  task automatic test_wait_and_stray_start();
    run_op(32'h0180_0042, 32'h0000_1000, 10, 5, -1);
    checks++; if (n_x !== 2 || x_addr[0] !== 32'h1004 || x_addr[1] !== 32'h1008) begin failures++;
      $display("FAIL wait_addr got=n%0d %h,%h exp=n2 1004,1008", n_x, x_addr[0], x_addr[1]); end
    checks++; if (x_reg[0] !== 5'd1 || x_reg[1] !== 5'd6) begin failures++;
      $display("FAIL wait_regs got=%0d,%0d exp=1,6", x_reg[0], x_reg[1]); end
    checks++; if (req_cycles !== 22 || addr_unstable !== 0) begin failures++;
      $display("FAIL wait_req_hold got=req%0d unstable%0d exp=22,0", req_cycles, addr_unstable); end
    checks++; if (n_l !== 0) begin failures++; $display("FAIL wait_rfload got=%0d exp=0", n_l); end
    checks++; if (done_cnt !== 1 || lat !== 27 || busy_after !== 0) begin failures++;
      $display("FAIL wait_done got=cnt%0d lat%0d busy_after%0d exp=1,27,0", done_cnt, lat, busy_after); end
  endtask

  task automatic test_reset_mid_op();
    run_op(32'h00A5_0003, 32'h0000_0080, 0, -1, 1);
    checks++; if (!aborted || snap !== 79'd0) begin failures++;
      $display("FAIL abort_async_zero got=%h aborted=%0d exp=0 aborted=1", snap, aborted); end
    checks++; if (n_l !== 0 || req_cycles !== 0 || done_cnt !== 0 || busy_cnt !== 0) begin failures++;
      $display("FAIL abort_quiet got=rfload%0d req%0d done%0d busy%0d exp=0,0,0,0", n_l, req_cycles, done_cnt, busy_cnt); end
    run_op(32'h00A1_0005, 32'h0000_0300, 1, -1, -1);
    checks++; if (n_x !== 2 || x_addr[0] !== 32'h300 || x_addr[1] !== 32'h304) begin failures++;
      $display("FAIL abort_recover_addr got=n%0d %h,%h exp=n2 300,304", n_x, x_addr[0], x_addr[1]); end
    checks++; if (done_cnt !== 1 || lat !== 10 || n_l !== 1 || l_wbval[0] !== 32'h308) begin failures++;
      $display("FAIL abort_recover_done got=cnt%0d lat%0d rf%0d wb%h exp=1,10,1,308", done_cnt, lat, n_l, l_wbval[0]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.IR = 32'd0; bus.rn_val = 32'd0; bus.mem_done = 1'b0;
    test_reset();
    test_stm_ia();
    test_ldm_db();
    test_ldm_base_in_list();
    test_empty_list();
    test_wait_and_stray_start();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
